// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter and its round-robin picker.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        GO,
        WAIT,
        RESP
    } state_t;

    localparam int SETTLE_W = 4;

    // Index width for n requesters; never below one bit so a 2-way arbiter still has a grant index.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 8; k++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0]   cand_sum [NUM_REQ];
    logic [IDX_W-1:0] cand     [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // cand[k] is the requester k positions after ptr; hit[k] says whether it is asking.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQ))
                            : cand_sum[gi][IDX_W-1:0];
            assign hit[gi] = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = |hit;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) idx = cand[k];
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one spi_master among NUM_REQ requesters, one word per grant,
// with per-requester mode/divider and per-slave chip-select demultiplexing.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int DATA_WIDTH        = 4,
    parameter int CLK_DIVIDER_WIDTH = 4,
    parameter int SETTLE_CYCLES     = 2,
    localparam int IDX_W            = clog2_min1(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 resetb,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
    input  logic [NUM_REQ-1:0]                   req_cpol,
    input  logic [NUM_REQ-1:0]                   req_cpha,
    input  logic [NUM_REQ*CLK_DIVIDER_WIDTH-1:0] req_div,
    output logic [NUM_REQ-1:0]                   ack,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 m_cpol,
    output logic                                 m_cpha,
    output logic [CLK_DIVIDER_WIDTH-1:0]         m_clk_divider,
    output logic                                 m_go,
    output logic [DATA_WIDTH-1:0]                m_datai,
    input  logic [DATA_WIDTH-1:0]                m_datao,
    input  logic                                 m_busy,
    input  logic                                 m_done,
    input  logic                                 m_csb,
    output logic [NUM_REQ-1:0]                   csb_out,
    output logic [IDX_W-1:0]                     grant_idx,
    output logic                                 busy
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t                  state_reg;
    logic [SETTLE_W-1:0]     settle_reg;
    logic [IDX_W-1:0]        ptr_reg;
    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    logic [NUM_REQ-1:0]      csb_next;
    logic [DATA_WIDTH-1:0]        data_slice [NUM_REQ];
    logic [CLK_DIVIDER_WIDTH-1:0] div_slice  [NUM_REQ];

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign div_slice[gi]  = req_div[gi*CLK_DIVIDER_WIDTH +: CLK_DIVIDER_WIDTH];
            // Only the granted slave sees the master's chip select.
            assign csb_next[gi] = ~((state_reg != IDLE) && (grant_idx == IDX_W'(gi)) && !m_csb);
        end
    endgenerate

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_reg     <= IDLE;
            settle_reg    <= '0;
            ptr_reg       <= '0;
            grant_idx     <= '0;
            ack           <= '0;
            rdata         <= '0;
            m_cpol        <= 1'b0;
            m_cpha        <= 1'b0;
            m_clk_divider <= '0;
            m_go          <= 1'b0;
            m_datai       <= '0;
            busy          <= 1'b0;
            csb_out       <= '1;
        end else begin
            ack     <= '0;
            m_go    <= 1'b0;
            csb_out <= csb_next;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx     <= pick_idx;
                        m_cpol        <= req_cpol[pick_idx];
                        m_cpha        <= req_cpha[pick_idx];
                        m_clk_divider <= div_slice[pick_idx];
                        m_datai       <= data_slice[pick_idx];
                        settle_reg    <= SETTLE_INIT;
                        busy          <= 1'b1;
                        state_reg     <= SETUP;
                    end
                end
                SETUP: begin
                    // Hold off go while the new CPOL settles and the master is still winding down.
                    if (settle_reg != '0) begin
                        settle_reg <= settle_reg - 1'b1;
                    end else if (!m_busy) begin
                        m_go      <= 1'b1;
                        state_reg <= GO;
                    end
                end
                GO: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (m_done) begin
                        ack       <= NUM_REQ'(1) << grant_idx;
                        rdata     <= m_datao;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (grant_idx == IDX_W'(NUM_REQ - 1)) ptr_reg <= '0;
                    else                                  ptr_reg <= grant_idx + 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
